// File: rtl/bnn_stream_loader.sv
// Binary image / filter-bank loader for the BNN datapath: two independent valid/ready
// bit-streams are packed into flat registers read in parallel by the convolution engine.
module bnn_stream_loader #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int N_FILT = 8,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      keep_wgt,
    input  logic                      pix_valid,
    input  logic [LANES-1:0]          pix_data,
    output logic                      pix_ready,
    input  logic                      wgt_valid,
    input  logic [LANES-1:0]          wgt_data,
    output logic                      wgt_ready,
    output logic [IMG_H*IMG_W-1:0]    pixels,
    output logic [N_FILT*K*K-1:0]     weights,
    output logic                      pix_done,
    output logic                      wgt_done,
    output logic                      load_done,
    output logic                      done_pulse
);
    localparam int PIX_N     = IMG_W * IMG_H;
    localparam int WGT_N     = N_FILT * K * K;
    localparam int PIX_BEATS = PIX_N / LANES;
    localparam int WGT_BEATS = WGT_N / LANES;
    localparam int PCW       = $clog2(PIX_BEATS + 1);
    localparam int WCW       = $clog2(WGT_BEATS + 1);

    generate
        if ((PIX_N % LANES) != 0 || (WGT_N % LANES) != 0) begin : g_lane_check
            $error("bnn_stream_loader: image and filter sizes must be multiples of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t           state_reg, state_next;
    logic [PCW-1:0]   pix_cnt_reg;
    logic [WCW-1:0]   wgt_cnt_reg;
    logic             pix_done_reg, wgt_done_reg, done_pulse_reg;
    logic [PIX_N-1:0] pixels_reg;
    logic [WGT_N-1:0] weights_reg;
    logic             retain_wgt, pix_acc, wgt_acc, pix_last, wgt_last;

    // start wins over any beat presented in the same cycle.
    assign retain_wgt = keep_wgt && wgt_done_reg;
    assign pix_ready  = (state_reg == LOAD) && !pix_done_reg;
    assign wgt_ready  = (state_reg == LOAD) && !wgt_done_reg;
    assign pix_acc    = pix_valid && pix_ready && !start;
    assign wgt_acc    = wgt_valid && wgt_ready && !start;
    assign pix_last   = pix_acc && (pix_cnt_reg == PCW'(PIX_BEATS - 1));
    assign wgt_last   = wgt_acc && (wgt_cnt_reg == WCW'(WGT_BEATS - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = LOAD;
        end else if (state_reg == LOAD &&
                     (pix_done_reg || pix_last) && (wgt_done_reg || wgt_last)) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_cnt_reg    <= '0;
            wgt_cnt_reg    <= '0;
            pix_done_reg   <= 1'b0;
            wgt_done_reg   <= 1'b0;
            done_pulse_reg <= 1'b0;
            pixels_reg     <= '0;
            weights_reg    <= '0;
        end else begin
            done_pulse_reg <= (state_reg == LOAD) && (state_next == DONE);
            if (start) begin
                // Stores are deliberately left intact; new beats overwrite them in order.
                pix_cnt_reg  <= '0;
                pix_done_reg <= 1'b0;
                if (!retain_wgt) begin
                    wgt_cnt_reg  <= '0;
                    wgt_done_reg <= 1'b0;
                end
            end else begin
                if (pix_acc) begin
                    pixels_reg[int'(pix_cnt_reg) * LANES +: LANES] <= pix_data;
                    pix_cnt_reg <= pix_cnt_reg + PCW'(1);
                    if (pix_last) pix_done_reg <= 1'b1;
                end
                if (wgt_acc) begin
                    weights_reg[int'(wgt_cnt_reg) * LANES +: LANES] <= wgt_data;
                    wgt_cnt_reg <= wgt_cnt_reg + WCW'(1);
                    if (wgt_last) wgt_done_reg <= 1'b1;
                end
            end
        end
    end

    assign pixels     = pixels_reg;
    assign weights    = weights_reg;
    assign pix_done   = pix_done_reg;
    assign wgt_done   = wgt_done_reg;
    assign load_done  = (state_reg == DONE);
    assign done_pulse = done_pulse_reg;
endmodule
